// File: rtl/hammer_campaign_ctrl.sv
// Rowhammer campaign sequencer: sweeps rows x two patterns over the tester,
// emitting one bit-flip result record per run on a valid/ready port.
module hammer_campaign_ctrl #(
  parameter int         ADDR_WIDTH     = 64,
  parameter int         ROW_WIDTH      = 12,
  parameter int         ROW_POS        = 10,
  parameter int         ROW_STEP       = 2,
  parameter int         ARM_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 1 << 24,
  parameter logic [3:0] FINISH_CODE    = 4'd5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ROW_WIDTH-1:0]  row_first,
  input  logic [ROW_WIDTH-1:0]  row_last,
  input  logic [31:0]           hammer_count,
  input  logic [63:0]           pattern_a,
  input  logic [63:0]           pattern_b,
  input  logic [3:0]            tst_state,
  input  logic [63:0]           tst_flips,
  output logic                  tst_reset,
  output logic [ADDR_WIDTH-1:0] cfg_address,
  output logic [31:0]           cfg_count,
  output logic [63:0]           cfg_pattern,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ROW_WIDTH-1:0]  res_row,
  output logic                  res_pat,
  output logic [63:0]           res_flips,
  output logic                  res_timeout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AC_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AC_W-1:0] ARM_LAST = AC_W'(ARM_CYCLES - 1);
  localparam logic [ROW_WIDTH:0] STEP = (ROW_WIDTH + 1)'(ROW_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CAPTURE,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [ROW_WIDTH-1:0] row_cur;
  logic [ROW_WIDTH-1:0] row_last_q;
  logic [63:0]          pat_a_q;
  logic [63:0]          pat_b_q;
  logic                 pat;
  logic [AC_W-1:0]      arm_cnt;
  logic [WD_W-1:0]      wd;
  logic                 to_flag;
  logic [ROW_WIDTH:0]   sum;
  logic                 finished;
  logic                 start_ok;

  // One extra bit so a step past the top row terminates instead of wrapping
  assign sum      = {1'b0, row_cur} + STEP;
  assign finished = (tst_state == FINISH_CODE);
  assign start_ok = start && (row_last >= row_first);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start_ok) state_n = S_ARM;
      S_ARM:     if (arm_cnt == ARM_LAST) state_n = S_RUN;
      S_RUN:     if (finished || wd == WD_LAST) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_EMIT;
      S_EMIT:    if (res_ready) state_n = S_NEXT;
      S_NEXT: begin
        if (!pat) state_n = S_ARM;
        else if (sum > {1'b0, row_last_q}) state_n = S_DONE;
        else state_n = S_ARM;
      end
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cur     <= '0;
      row_last_q  <= '0;
      cfg_count   <= '0;
      pat_a_q     <= '0;
      pat_b_q     <= '0;
      pat         <= 1'b0;
      arm_cnt     <= '0;
      wd          <= '0;
      to_flag     <= 1'b0;
      res_row     <= '0;
      res_pat     <= 1'b0;
      res_flips   <= '0;
      res_timeout <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && (row_last < row_first);
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            row_cur    <= row_first;
            row_last_q <= row_last;
            cfg_count  <= hammer_count;
            pat_a_q    <= pattern_a;
            pat_b_q    <= pattern_b;
            pat        <= 1'b0;
            arm_cnt    <= '0;
            wd         <= '0;
          end
        end
        S_ARM: begin
          arm_cnt <= arm_cnt + 1'b1;
          wd      <= '0;
        end
        S_RUN: begin
          wd      <= wd + 1'b1;
          to_flag <= !finished;
        end
        S_CAPTURE: begin
          res_row     <= row_cur;
          res_pat     <= pat;
          res_flips   <= to_flag ? '1 : tst_flips;
          res_timeout <= to_flag;
        end
        S_NEXT: begin
          arm_cnt <= '0;
          if (!pat) begin
            pat <= 1'b1;
          end else begin
            pat <= 1'b0;
            if (sum <= {1'b0, row_last_q}) row_cur <= sum[ROW_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_address = ADDR_WIDTH'(row_cur) << ROW_POS;
  assign cfg_pattern = pat ? pat_b_q : pat_a_q;
  assign busy        = (state != S_IDLE);
  // abort forces the tester into reset and drops the record in the same cycle
  assign tst_reset   = (state != S_RUN) || abort;
  assign res_valid   = (state == S_EMIT) && !abort;
  assign done        = (state == S_DONE) && !abort;

endmodule

// File: tb/tb_hammer_campaign_ctrl.sv
// Scoreboard bench for hammer_campaign_ctrl with a behavioural tester model
// and a queue of expected result records.
module tb_hammer_campaign_ctrl;

  localparam int TO   = 64;
  localparam int STEP = 2;
  localparam logic [63:0] FK = 64'hC3C3_0000_0000_5A5A;

  typedef struct packed {
    logic [11:0] row;
    logic        pat;
    logic [63:0] flips;
    logic        to;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [11:0] row_first;
  logic [11:0] row_last;
  logic [31:0] hammer_count;
  logic [63:0] pattern_a;
  logic [63:0] pattern_b;
  logic [3:0]  tst_state;
  logic [63:0] tst_flips;
  logic        tst_reset;
  logic [63:0] cfg_address;
  logic [31:0] cfg_count;
  logic [63:0] cfg_pattern;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [11:0] res_row;
  logic        res_pat;
  logic [63:0] res_flips;
  logic        res_timeout;
  logic        busy;
  logic        done;
  logic        err;

  hammer_campaign_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .row_first(row_first), .row_last(row_last),
    .hammer_count(hammer_count),
    .pattern_a(pattern_a), .pattern_b(pattern_b),
    .tst_state(tst_state), .tst_flips(tst_flips),
    .tst_reset(tst_reset), .cfg_address(cfg_address),
    .cfg_count(cfg_count), .cfg_pattern(cfg_pattern),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_pat(res_pat),
    .res_flips(res_flips), .res_timeout(res_timeout),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int lat = 10;
  int rdy_mode = 0;
  int stall_n = 0;
  int tcnt = 0;
  rec_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Tester: finishes lat cycles after leaving reset; flips depend on config
  always @(posedge clk) tcnt <= tst_reset ? 0 : tcnt + 1;
  assign tst_state = (tcnt >= lat) ? 4'd5 : 4'd1;
  assign tst_flips = cfg_pattern ^ cfg_address ^ {32'h0, cfg_count} ^ FK;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      2: begin
        if (stall_n < 20) begin
          res_ready = 1'b0;
          if (res_valid) stall_n++;
        end else res_ready = 1'b1;
      end
      default: res_ready = 1'b0;
    endcase
  end

  logic stalled_prev = 1'b0;
  rec_t held;
  rec_t cur;
  rec_t e;

  always @(negedge clk) begin
    if (!reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      cur = '{res_row, res_pat, res_flips, res_timeout};
      if (res_valid) begin
        chk("emit_tst_reset", 64'(tst_reset), 64'd1);
        if (stalled_prev) chk("stall_stable", 64'(cur != held), 64'd0);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_record", 64'(res_row), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("rec_row", 64'(res_row), 64'(e.row));
          chk("rec_pat", 64'(res_pat), 64'(e.pat));
          chk("rec_flips", res_flips, e.flips);
          chk("rec_timeout", 64'(res_timeout), 64'(e.to));
        end
      end
      stalled_prev = res_valid && !res_ready;
      held = cur;
    end
  end

  function automatic rec_t model(int r, int p, logic [31:0] hc,
                                 logic [63:0] pa, logic [63:0] pb, int l);
    rec_t m;
    logic [63:0] addr;
    addr = 64'(r) << 10;
    m.row = 12'(r);
    m.pat = (p != 0);
    m.to = (l >= TO);
    m.flips = m.to ? '1 : (((p != 0) ? pb : pa) ^ addr ^ {32'h0, hc} ^ FK);
    return m;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic scramble();
    row_first = 12'($urandom);
    row_last = 12'($urandom);
    hammer_count = $urandom;
    pattern_a = {$urandom, $urandom};
    pattern_b = {$urandom, $urandom};
  endtask

  task automatic campaign(input int rf, input int rl, input int lat_i,
                          input int mode);
    logic [31:0] hc;
    logic [63:0] pa, pb;
    int d0, k;
    hc = $urandom;
    pa = {$urandom, $urandom};
    pb = {$urandom, $urandom};
    @(posedge clk); #1;
    lat = lat_i;
    rdy_mode = mode;
    stall_n = 0;
    row_first = 12'(rf);
    row_last = 12'(rl);
    hammer_count = hc;
    pattern_a = pa;
    pattern_b = pb;
    start = 1'b1;
    for (int r = rf; r <= rl; r += STEP)
      for (int p = 0; p < 2; p++) sb.push_back(model(r, p, hc, pa, pb, lat_i));
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    row_first = 12'd0;
    row_last = 12'hFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("done_pulse", 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("tst_reset_idle", 64'(tst_reset), 64'd1);
    chk("records_left", 64'(sb.size()), 64'd0);
    if (k >= 20000) begin
      sb.delete();
      do_reset();
    end
  endtask

  task automatic start_hang(output bit ok);
    int k;
    @(posedge clk); #1;
    lat = 100000;
    row_first = 12'd30;
    row_last = 12'd40;
    hammer_count = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (tst_reset && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (k < 50);
    chk("run_reached", 64'(ok), 64'd1);
  endtask

  initial begin
    bit ok;
    int d0, k, rf, rl;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    row_first = '0;
    row_last = '0;
    hammer_count = '0;
    pattern_a = '0;
    pattern_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tst_reset", 64'(tst_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_cfg_addr", cfg_address, 64'd0);
    chk("rst_cfg_cnt", 64'(cfg_count), 64'd0);
    chk("rst_cfg_pat", cfg_pattern, 64'd0);
    chk("rst_res_flips", res_flips, 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    reset = 1'b1;

    campaign(100, 104, 50, 0);
    campaign(4095, 4095, 7, 1);

    @(posedge clk); #1;
    row_first = 12'd10;
    row_last = 12'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_tst_reset", 64'(tst_reset), 64'd1);
    @(posedge clk); #1;
    chk("err_clear", 64'(err), 64'd0);
    chk("err_busy2", 64'(busy), 64'd0);

    campaign(20, 23, 100000, 0);
    campaign(7, 7, TO - 1, 0);
    campaign(7, 8, TO, 1);
    campaign(50, 52, 3, 2);

    for (int i = 0; i < 8; i++) begin
      rf = $urandom_range(0, 4095);
      rl = rf + $urandom_range(0, 9);
      if (rl > 4095) rl = 4095;
      campaign(rf, rl, $urandom_range(0, 70), 1);
    end

    rdy_mode = 0;
    d0 = done_cnt;
    start_hang(ok);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    #1;
    chk("abort_run_tst_reset", 64'(tst_reset), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_run_busy", 64'(busy), 64'd0);
    chk("abort_run_tst_reset2", 64'(tst_reset), 64'd1);
    repeat (10) @(posedge clk);
    chk("abort_run_no_done", 64'(done_cnt - d0), 64'd0);

    @(posedge clk); #1;
    lat = 4;
    rdy_mode = 3;
    row_first = 12'd200;
    row_last = 12'd210;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!res_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("emit_reached", 64'(k < 100), 64'd1);
    @(posedge clk); #2;
    rdy_mode = 0;
    res_ready = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_emit_valid", 64'(res_valid), 64'd0);
    chk("abort_emit_tst_reset", 64'(tst_reset), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_emit_busy", 64'(busy), 64'd0);
    repeat (10) @(posedge clk);
    chk("abort_emit_no_done", 64'(done_cnt - d0), 64'd0);

    start_hang(ok);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_tst_reset", 64'(tst_reset), 64'd1);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_cfg_addr", cfg_address, 64'd0);
    chk("async_cfg_cnt", 64'(cfg_count), 64'd0);
    chk("async_outs", {59'd0, res_valid, done, err, res_pat, res_timeout}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    campaign(300, 305, 12, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
